// File: rtl/arb_merge_4b_8to1_if.sv
// arb_merge_4b_8to1_if: eight 4-bit val/rdy source channels plus one merged output stream.
interface arb_merge_4b_8to1_if;
  logic [3:0] in0, in1, in2, in3, in4, in5, in6, in7;
  logic [7:0] in_val;
  logic [7:0] in_rdy;
  logic [3:0] out;
  logic [2:0] out_sel;
  logic       out_val;
  logic       out_rdy;
  modport master (
    output in0, in1, in2, in3, in4, in5, in6, in7, in_val, out_rdy,
    input  in_rdy, out, out_sel, out_val
  );
  modport slave (
    input  in0, in1, in2, in3, in4, in5, in6, in7, in_val, out_rdy,
    output in_rdy, out, out_sel, out_val
  );
endinterface

// File: rtl/arb_merge_4b_8to1.sv
// arb_merge_4b_8to1: round-robin merge of eight 4-bit val/rdy channels into one registered stream.
module arb_merge_4b_8to1 (
  input logic               clk,
  input logic               reset,
  arb_merge_4b_8to1_if.slave bus
);
  logic [3:0] pay [8];
  logic [3:0] out_q, out_d;
  logic [2:0] sel_q, sel_d;
  logic       val_q, val_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] g;
  logic       found, space, grant;
  assign pay = '{bus.in0, bus.in1, bus.in2, bus.in3, bus.in4, bus.in5, bus.in6, bus.in7};
  assign space = !val_q || bus.out_rdy;
  // Search starts at ptr and wraps naturally through the 3-bit add.
  always_comb begin
    g = 3'd0;
    found = 1'b0;
    for (int i = 0; i < 8; i++)
      if (!found && bus.in_val[3'(ptr_q + 3'(i))]) begin
        g = 3'(ptr_q + 3'(i));
        found = 1'b1;
      end
  end
  assign grant = space && found && !reset;
  assign bus.in_rdy = grant ? 8'(8'd1 << g) : 8'd0;
  always_comb begin
    out_d = grant ? pay[g] : out_q;
    sel_d = grant ? g : sel_q;
    val_d = grant ? 1'b1 : (bus.out_rdy ? 1'b0 : val_q);
    ptr_d = grant ? 3'(g + 3'd1) : ptr_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= 4'd0;
      sel_q <= 3'd0;
      val_q <= 1'b0;
      ptr_q <= 3'd0;
    end else begin
      out_q <= out_d;
      sel_q <= sel_d;
      val_q <= val_d;
      ptr_q <= ptr_d;
    end
  end
  assign bus.out = out_q;
  assign bus.out_sel = sel_q;
  assign bus.out_val = val_q;
endmodule

// File: tb/tb_arb_merge_4b_8to1.sv
// tb_arb_merge_4b_8to1: directed and scoreboarded checks of the round-robin 8-to-1 merge.
module tb_arb_merge_4b_8to1;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] pay [8];
  int tests = 0;
  int fails = 0;
  arb_merge_4b_8to1_if bus ();
  arb_merge_4b_8to1 dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  assign bus.in0 = pay[0];
  assign bus.in1 = pay[1];
  assign bus.in2 = pay[2];
  assign bus.in3 = pay[3];
  assign bus.in4 = pay[4];
  assign bus.in5 = pay[5];
  assign bus.in6 = pay[6];
  assign bus.in7 = pay[7];
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    reset = 1'b1;
    bus.in_val = 8'h00;
    bus.out_rdy = 1'b0;
    tick();
    reset = 1'b0;
  endtask
  task automatic test_reset;
    reset = 1'b1;
    bus.in_val = 8'hFF;
    bus.out_rdy = 1'b1;
    for (int k = 0; k < 8; k++) pay[k] = 4'hF;
    tick();
    tick();
    tests++;
    if (bus.in_rdy !== 8'h00) begin fails++; $display("FAIL reset_in_rdy got %h want 00", bus.in_rdy); end
    tests++;
    if ({bus.out_val, bus.out, bus.out_sel} !== 8'h00) begin
      fails++; $display("FAIL reset_outputs got val=%b out=%h sel=%0d want 0/0/0", bus.out_val, bus.out, bus.out_sel);
    end
    reset = 1'b0;
    bus.in_val = 8'h00;
  endtask
  task automatic test_single;
    do_reset();
    pay[0] = 4'h5;
    bus.in_val = 8'h01;
    bus.out_rdy = 1'b1;
    #1;
    tests++;
    if (bus.in_rdy !== 8'h01) begin fails++; $display("FAIL single_in_rdy got %h want 01", bus.in_rdy); end
    tick();
    bus.in_val = 8'h00;
    tests++;
    if (bus.out_val !== 1'b1 || bus.out !== 4'h5 || bus.out_sel !== 3'd0) begin
      fails++; $display("FAIL single_out got val=%b out=%h sel=%0d want 1/5/0", bus.out_val, bus.out, bus.out_sel);
    end
  endtask
  task automatic test_round_robin;
    do_reset();
    for (int k = 0; k < 8; k++) pay[k] = 4'(k);
    bus.in_val = 8'hFF;
    bus.out_rdy = 1'b1;
    for (int c = 0; c < 9; c++) begin
      #1;
      tests++;
      if (bus.in_rdy !== 8'(1 << (c % 8))) begin
        fails++; $display("FAIL rr_grant c=%0d got %h want %h", c, bus.in_rdy, 8'(1 << (c % 8)));
      end
      tick();
      tests++;
      if (bus.out_val !== 1'b1 || bus.out_sel !== 3'(c % 8) || bus.out !== 4'(c % 8)) begin
        fails++; $display("FAIL rr_out c=%0d got val=%b out=%h sel=%0d want 1/%0d/%0d", c, bus.out_val, bus.out, bus.out_sel, c % 8, c % 8);
      end
    end
    bus.in_val = 8'h00;
  endtask
  task automatic test_ptr_wrap;
    do_reset();
    bus.in_val = 8'h04;
    bus.out_rdy = 1'b1;
    tick();
    bus.in_val = 8'h82;
    #1;
    tests++;
    if (bus.in_rdy !== 8'h80) begin fails++; $display("FAIL wrap_grant7 got %h want 80", bus.in_rdy); end
    tick();
    tests++;
    if (bus.out_sel !== 3'd7) begin fails++; $display("FAIL wrap_sel7 got %0d want 7", bus.out_sel); end
    #1;
    tests++;
    if (bus.in_rdy !== 8'h02) begin fails++; $display("FAIL wrap_grant1 got %h want 02", bus.in_rdy); end
    tick();
    tests++;
    if (bus.out_sel !== 3'd1) begin fails++; $display("FAIL wrap_sel1 got %0d want 1", bus.out_sel); end
    bus.in_val = 8'h00;
  endtask
  task automatic test_stall_and_drain;
    do_reset();
    pay[0] = 4'h9;
    pay[4] = 4'hC;
    bus.in_val = 8'h01;
    bus.out_rdy = 1'b0;
    tick();
    bus.in_val = 8'h10;
    for (int c = 0; c < 3; c++) begin
      #1;
      tests++;
      if (bus.in_rdy !== 8'h00) begin fails++; $display("FAIL stall_in_rdy c=%0d got %h want 00", c, bus.in_rdy); end
      tick();
      tests++;
      if (bus.out_val !== 1'b1 || bus.out !== 4'h9 || bus.out_sel !== 3'd0) begin
        fails++; $display("FAIL stall_hold c=%0d got val=%b out=%h sel=%0d want 1/9/0", c, bus.out_val, bus.out, bus.out_sel);
      end
    end
    bus.out_rdy = 1'b1;
    #1;
    tests++;
    if (bus.in_rdy !== 8'h10) begin fails++; $display("FAIL stall_release got %h want 10", bus.in_rdy); end
    tick();
    tests++;
    if (bus.out_val !== 1'b1 || bus.out !== 4'hC || bus.out_sel !== 3'd4) begin
      fails++; $display("FAIL stall_replace got val=%b out=%h sel=%0d want 1/c/4", bus.out_val, bus.out, bus.out_sel);
    end
    bus.in_val = 8'h00;
    tick();
    tests++;
    if (bus.out_val !== 1'b0 || bus.out !== 4'hC || bus.out_sel !== 3'd4) begin
      fails++; $display("FAIL drain got val=%b out=%h sel=%0d want 0/c/4", bus.out_val, bus.out, bus.out_sel);
    end
  endtask
  task automatic test_reset_mid_stall;
    do_reset();
    pay[0] = 4'h3;
    pay[5] = 4'h6;
    bus.in_val = 8'h01;
    bus.out_rdy = 1'b0;
    tick();
    reset = 1'b1;
    bus.in_val = 8'hFF;
    bus.out_rdy = 1'b1;
    #1;
    tests++;
    if (bus.in_rdy !== 8'h00) begin fails++; $display("FAIL midreset_in_rdy got %h want 00", bus.in_rdy); end
    tick();
    tests++;
    if (bus.out_val !== 1'b0 || bus.out !== 4'h0 || bus.out_sel !== 3'd0) begin
      fails++; $display("FAIL midreset_out got val=%b out=%h sel=%0d want 0/0/0", bus.out_val, bus.out, bus.out_sel);
    end
    reset = 1'b0;
    bus.in_val = 8'h21;
    #1;
    tests++;
    if (bus.in_rdy !== 8'h01) begin fails++; $display("FAIL midreset_ptr got %h want 01", bus.in_rdy); end
    bus.in_val = 8'h00;
  endtask
  task automatic test_random;
    int m_ptr, m_out, m_sel, g;
    bit m_val, found, space;
    logic [7:0] exp_rdy;
    do_reset();
    m_ptr = 0; m_out = 0; m_sel = 0; m_val = 0;
    for (int c = 0; c < 20; c++) begin
      for (int k = 0; k < 8; k++) pay[k] = 4'($urandom_range(0, 15));
      bus.in_val = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
      bus.out_rdy = 1'($urandom_range(0, 3) != 0);
      space = !m_val || bus.out_rdy;
      found = 0;
      g = 0;
      for (int i = 0; i < 8; i++)
        if (!found && bus.in_val[(m_ptr + i) % 8]) begin found = 1; g = (m_ptr + i) % 8; end
      exp_rdy = (space && found) ? 8'(1 << g) : 8'h00;
      #1;
      tests++;
      if (bus.in_rdy !== exp_rdy) begin fails++; $display("FAIL rand_in_rdy c=%0d got %h want %h", c, bus.in_rdy, exp_rdy); end
      if (space && found) begin
        m_out = int'(pay[g]); m_sel = g; m_val = 1; m_ptr = (g + 1) % 8;
      end else if (bus.out_rdy) m_val = 0;
      tick();
      tests++;
      if (bus.out_val !== m_val || bus.out !== 4'(m_out) || bus.out_sel !== 3'(m_sel)) begin
        fails++; $display("FAIL rand_out c=%0d got val=%b out=%h sel=%0d want %b/%h/%0d", c, bus.out_val, bus.out, bus.out_sel, m_val, m_out, m_sel);
      end
    end
    bus.in_val = 8'h00;
  endtask
  initial begin
    bus.in_val = 8'h00;
    bus.out_rdy = 1'b0;
    for (int k = 0; k < 8; k++) pay[k] = 4'h0;
    test_reset();
    test_single();
    test_round_robin();
    test_ptr_wrap();
    test_stall_and_drain();
    test_reset_mid_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
